bp_sacc_link_arbiter: RTL and testbench



---
 rtl/bp_sacc_link_arbiter.sv | 159 +++++++++++++++
 tb/tb_bp_sacc_link_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_sacc_link_arbiter.sv
// bp_sacc_link_arbiter
// Wormhole-aware round-robin arbiter. Merges num_req_p ready-and-valid flit
// streams onto one coherence NoC link. Once a multi-flit packet's header is
// accepted, the grant stays on that requester until the whole packet has
// crossed, so packets from different tiles are never interleaved.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   data_i       per-requester flits, requester k at [k*flit_width_p +: flit_width_p]
//   v_i          per-requester flit valid
//   ready_and_o  per-requester ready (only the selected requester sees ready_and_i)
//   data_o       merged flit
//   v_o          merged valid
//   ready_and_i  downstream ready
//   grant_o      one-hot current selection, zero when nothing is selected
//   busy_o       high while a multi-flit packet holds the lock
module bp_sacc_link_arbiter #(
  parameter int num_req_p    = 4,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p*flit_width_p-1:0] data_i,
  input  logic [num_req_p-1:0]              v_i,
  output logic [num_req_p-1:0]              ready_and_o,
  output logic [flit_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_and_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              busy_o
);

  localparam int IDX_W = $clog2(num_req_p);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mode_t;

  mode_t                   r_mode;
  mode_t                   w_mode_nxt;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        w_rr_ptr_nxt;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        w_owner_nxt;
  logic [len_width_p-1:0]  r_cnt;
  logic [len_width_p-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]        w_sel;
  logic                    w_active;
  logic                    w_xfer;
  logic [flit_width_p-1:0] w_flit;
  logic [len_width_p-1:0]  w_hdr_len;

  // Requester index after idx, wrapping at num_req_p (which need not be a
  // power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == num_req_p - 1) return '0;
    return idx + 1'b1;
  endfunction

  // base + off modulo num_req_p; off is always below num_req_p.
  function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] base,
                                               input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= num_req_p) sum = sum - num_req_p;
    return IDX_W'(sum);
  endfunction

  // Selection: the lock owner while BUSY, otherwise the first valid requester
  // scanning from the round-robin pointer. The scan runs from the farthest
  // offset down so the nearest valid requester is the last one written.
  always_comb begin
    w_sel    = r_owner;
    w_active = 1'b0;
    if (r_mode == BUSY) begin
      w_sel    = r_owner;
      w_active = 1'b1;
    end else begin
      for (int i = num_req_p - 1; i >= 0; i--) begin
        if (v_i[ptr_add(r_rr_ptr, i)]) begin
          w_sel    = ptr_add(r_rr_ptr, i);
          w_active = 1'b1;
        end
      end
    end
    if (reset_i) w_active = 1'b0;
  end

  assign w_flit    = data_i[int'(w_sel)*flit_width_p +: flit_width_p];
  assign w_hdr_len = w_flit[len_offset_p +: len_width_p];

  // Zero-latency datapath. ready_and_o for the selected requester follows the
  // downstream ready without looking at that requester's own valid, so an
  // owner that bubbles still sees ready.
  always_comb begin
    grant_o     = '0;
    ready_and_o = '0;
    v_o         = 1'b0;
    data_o      = '0;
    busy_o      = 1'b0;
    if (w_active) begin
      grant_o[w_sel]     = 1'b1;
      ready_and_o[w_sel] = ready_and_i;
      v_o                = v_i[w_sel];
      data_o             = w_flit;
      busy_o             = (r_mode == BUSY);
    end
  end

  assign w_xfer = v_o & ready_and_i;

  // Next-state: only a completed handshake moves the arbiter. A header with a
  // zero length field is a whole packet, so the pointer advances immediately.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = r_cnt;
    if (w_xfer) begin
      if (r_mode == IDLE) begin
        if (w_hdr_len == '0) begin
          w_rr_ptr_nxt = wrap_inc(w_sel);
        end else begin
          w_mode_nxt  = BUSY;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = w_hdr_len;
        end
      end else begin
        // Counter is at least 1 in BUSY; a value of 1 means this is the tail.
        if (r_cnt <= len_width_p'(1)) begin
          w_mode_nxt   = IDLE;
          w_rr_ptr_nxt = wrap_inc(r_owner);
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - len_width_p'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mode   <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bp_sacc_link_arbiter.sv
// Testbench for bp_sacc_link_arbiter: fixed vector table, hand-written
// reset-mid-packet sequence, and a randomized soak against a packet-level
// reference model with an output scoreboard.
module tb_bp_sacc_link_arbiter;

  localparam int N  = 4;
  localparam int FW = 64;
  localparam int LW = 4;
  localparam int LO = 0;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*FW-1:0] data_i;
  logic [N-1:0]    v_i;
  logic [N-1:0]    ready_and_o;
  logic [FW-1:0]   data_o;
  logic            v_o;
  logic            ready_and_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  bp_sacc_link_arbiter #(
    .num_req_p   (N),
    .flit_width_p(FW),
    .len_width_p (LW),
    .len_offset_p(LO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .v_i        (v_i),
    .ready_and_o(ready_and_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_and_i(ready_and_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Flit layout used by the bench: [47:40] packet length, [39:32] requester,
  // [31:16] packet number, [15:8] flit index, [3:0] length field on headers and
  // random junk on body flits.
  function automatic logic [FW-1:0] mkflit(int k, int p, int f, int len, logic [3:0] junk);
    logic [FW-1:0] d;
    d        = '0;
    d[47:40] = 8'(len);
    d[39:32] = 8'(k);
    d[31:16] = 16'(p);
    d[15:8]  = 8'(f);
    d[3:0]   = (f == 0) ? 4'(len) : junk;
    return d;
  endfunction

  task automatic set_hdrs(input logic [15:0] lens);
    for (int k = 0; k < N; k++)
      data_i[k*FW +: FW] = mkflit(k, 0, 0, int'(lens[k*4 +: 4]), 4'h0);
  endtask

  // ---------------- reference model (packet-level) ----------------
  int m_busy = 0, m_ptr = 0, m_owner = 0, m_rem = 0;

  task automatic model_outputs(output logic [N-1:0] g, output logic vo,
                               output logic [N-1:0] r, output logic b, output int sel);
    g = '0; vo = 1'b0; r = '0; b = 1'b0; sel = -1;
    if (reset_i) return;
    if (m_busy != 0) sel = m_owner;
    else
      for (int i = 0; i < N; i++)
        if (sel < 0 && v_i[(m_ptr + i) % N]) sel = (m_ptr + i) % N;
    if (sel >= 0) begin
      g[sel] = 1'b1;
      vo     = v_i[sel];
      r[sel] = ready_and_i;
      b      = (m_busy != 0);
    end
  endtask

  task automatic model_advance(input int sel);
    int len;
    if (reset_i) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_rem = 0;
      return;
    end
    if (sel < 0) return;
    if (!(v_i[sel] && ready_and_i)) return;
    if (m_busy == 0) begin
      len = int'(data_i[sel*FW + LO +: LW]);
      if (len == 0) m_ptr = (sel + 1) % N;
      else begin
        m_busy = 1; m_owner = sel; m_rem = len;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  // Sample at the falling edge, compare to the model, then advance the model
  // with the same inputs the DUT will see at the next rising edge.
  task automatic mcycle();
    logic [N-1:0] g, r;
    logic         vo, b;
    int           sel;
    @(negedge clk);
    model_outputs(g, vo, r, b, sel);
    check("m.grant", 64'(grant_o), 64'(g));
    check("m.v_o", 64'(v_o), 64'(vo));
    check("m.ready", 64'(ready_and_o), 64'(r));
    check("m.busy", 64'(busy_o), 64'(b));
    if (reset_i) check("m.rst_data", data_o, 64'h0);
    else if (vo) check("m.data", data_o, data_i[sel*FW +: FW]);
    model_advance(sel);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        rdy;
    logic [15:0] lens;
    logic [3:0]  eg;
    logic        evo;
    logic [3:0]  erdy;
    logic        eb;
  } vec_t;

  vec_t tbl[19];

  // soak state
  int         f[N], p[N], L[N], exp_pkt[N], exp_flit[N], wait_cnt[N];
  logic [3:0] junk[N];
  int         o_rem, o_owner, o_next, src_hs, out_hs;

  initial begin
    reset_i     = 1'b1;
    v_i         = '0;
    ready_and_i = 1'b1;
    data_i      = '0;

    //            rst   v        rdy   lens      grant    vo    ready    busy
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 16'h0000, 4'b0001, 1'b1, 4'b0001, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 16'h0000, 4'b0010, 1'b1, 4'b0010, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 16'h0000, 4'b0100, 1'b1, 4'b0100, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 16'h0000, 4'b1000, 1'b1, 4'b1000, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 16'h0000, 4'b0001, 1'b1, 4'b0001, 1'b0};
    tbl[6]  = '{1'b0, 4'b1011, 1'b1, 16'h0030, 4'b0010, 1'b1, 4'b0010, 1'b0};
    tbl[7]  = '{1'b0, 4'b1011, 1'b1, 16'h0030, 4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[8]  = '{1'b0, 4'b1011, 1'b1, 16'h0030, 4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[9]  = '{1'b0, 4'b1011, 1'b1, 16'h0030, 4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[10] = '{1'b0, 4'b1011, 1'b1, 16'h0030, 4'b1000, 1'b1, 4'b1000, 1'b0};
    tbl[11] = '{1'b0, 4'b0001, 1'b1, 16'h0002, 4'b0001, 1'b1, 4'b0001, 1'b0};
    tbl[12] = '{1'b0, 4'b0011, 1'b0, 16'h0002, 4'b0001, 1'b1, 4'b0000, 1'b1};
    tbl[13] = '{1'b0, 4'b0011, 1'b0, 16'h0002, 4'b0001, 1'b1, 4'b0000, 1'b1};
    tbl[14] = '{1'b0, 4'b0011, 1'b1, 16'h0002, 4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[15] = '{1'b0, 4'b0010, 1'b1, 16'h0002, 4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[16] = '{1'b0, 4'b0011, 1'b1, 16'h0002, 4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[17] = '{1'b0, 4'b0011, 1'b1, 16'h0002, 4'b0010, 1'b1, 4'b0010, 1'b0};
    tbl[18] = '{1'b0, 4'b0000, 1'b1, 16'h0002, 4'b0000, 1'b0, 4'b0000, 1'b0};

    for (int i = 0; i < 19; i++) begin
      int gi;
      reset_i     = tbl[i].rst;
      v_i         = tbl[i].v;
      ready_and_i = tbl[i].rdy;
      set_hdrs(tbl[i].lens);
      @(negedge clk);
      check("tbl.grant", 64'(grant_o), 64'(tbl[i].eg));
      check("tbl.v_o", 64'(v_o), 64'(tbl[i].evo));
      check("tbl.ready", 64'(ready_and_o), 64'(tbl[i].erdy));
      check("tbl.busy", 64'(busy_o), 64'(tbl[i].eb));
      if (tbl[i].rst) check("tbl.rst_data", data_o, 64'h0);
      if (tbl[i].evo) begin
        gi = 0;
        for (int k = 0; k < N; k++) if (tbl[i].eg[k]) gi = k;
        check("tbl.data", data_o, mkflit(gi, 0, 0, int'(tbl[i].lens[gi*4 +: 4]), 4'h0));
      end
      next_edge();
    end

    // Reset in the middle of a packet on requester 2 (L=5).
    reset_i = 1'b1; v_i = '0; set_hdrs(16'h0000);
    mcycle(); next_edge();
    reset_i = 1'b0; v_i = 4'b0100; set_hdrs(16'h0500);
    mcycle(); check("rst.hdr_grant", 64'(grant_o), 64'h4); next_edge();
    mcycle(); check("rst.body1_busy", 64'(busy_o), 64'h1); next_edge();
    mcycle(); check("rst.body2_busy", 64'(busy_o), 64'h1); next_edge();
    reset_i = 1'b1; v_i = 4'b1111; set_hdrs(16'h0000);
    mcycle(); check("rst.v_o", 64'(v_o), 64'h0); check("rst.busy", 64'(busy_o), 64'h0); next_edge();
    reset_i = 1'b0;
    mcycle(); check("rst.regrant", 64'(grant_o), 64'h1); next_edge();
    // Abandoned lock must be gone: a second single flit moves on to req 1.
    mcycle(); check("rst.rr_next", 64'(grant_o), 64'h2); next_edge();

    // Randomized soak.
    reset_i = 1'b1; v_i = '0;
    mcycle(); next_edge();
    reset_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      f[k] = 0; p[k] = 0; L[k] = $urandom_range(15); junk[k] = 4'h0;
      exp_pkt[k] = 0; exp_flit[k] = 0; wait_cnt[k] = 0;
    end
    o_rem = 0; o_owner = 0; o_next = 0; src_hs = 0; out_hs = 0;

    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        v_i[k] = v_i[k] ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
        data_i[k*FW +: FW] = mkflit(k, p[k], f[k], L[k], junk[k]);
      end
      ready_and_i = ($urandom_range(3) != 0);
      mcycle();

      for (int k = 0; k < N; k++)
        if (!(v_i[k] && f[k] == 0)) wait_cnt[k] = 0;

      if (v_o && ready_and_i) begin
        int r, pk, fi, ln;
        out_hs++;
        r  = int'(data_o[39:32]);
        pk = int'(data_o[31:16]);
        fi = int'(data_o[15:8]);
        ln = int'(data_o[47:40]);
        if (o_rem > 0) begin
          check("sb.no_interleave", 64'(r), 64'(o_owner));
          check("sb.body_idx", 64'(fi), 64'(o_next));
          o_rem--; o_next++;
        end else begin
          check("sb.header_first", 64'(fi), 64'h0);
          o_owner = r; o_rem = ln; o_next = 1;
          for (int k = 0; k < N; k++)
            if (k != r && v_i[k] && f[k] == 0) wait_cnt[k]++;
          if (r < N) begin
            checks++;
            if (wait_cnt[r] > N - 1) begin
              errors++;
              if (errors <= 40) $display("FAIL fair.wait req=%0d actual=%0d required<=%0d", r, wait_cnt[r], N - 1);
            end
            wait_cnt[r] = 0;
          end
        end
        if (r < N) begin
          check("sb.pkt_order", 64'(pk), 64'(exp_pkt[r]));
          check("sb.flit_order", 64'(fi), 64'(exp_flit[r]));
          exp_flit[r]++;
          if (exp_flit[r] > ln) begin
            exp_flit[r] = 0; exp_pkt[r]++;
          end
        end else begin
          check("sb.req_id", 64'(r), 64'(N - 1));
        end
      end

      for (int k = 0; k < N; k++) begin
        if (v_i[k] && ready_and_o[k]) begin
          src_hs++;
          f[k]++;
          junk[k] = 4'($urandom_range(15));
          if (f[k] > L[k]) begin
            f[k] = 0; p[k]++; L[k] = $urandom_range(15);
          end
        end
      end
      next_edge();
    end
    check("sb.flit_count", 64'(out_hs), 64'(src_hs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
